dtree_stream_harness: RTL and testbench
=======================================

DTREE_STREAM_HARNESS -- requirements
Module: dtree_stream_harness

Interface
REQ-001 SHALL provide parameter NUM_FEAT, default 18, meaning features per inference frame.
REQ-002 SHALL provide parameter FEAT_W, default 8, meaning bits per feature.
REQ-003 SHALL provide parameter CLASS_W, default 2, meaning class-index width; the number of classes is 2**CLASS_W.
REQ-004 SHALL provide parameter EVAL_CYCLES, default 1, range >=1, meaning settle cycles allowed for the external combinational tree.
REQ-005 SHALL provide parameter CNT_W, default 16, meaning per-class counter width.
REQ-006 SHALL provide port clk  input  1  sole clock, rising edge.
REQ-007 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL provide port in_valid  input  1  feature beat valid.
REQ-009 SHALL provide port in_ready  output  1  feature beat accepted when in_valid&in_ready.
REQ-010 SHALL provide port in_data  input  FEAT_W  feature value, unsigned.
REQ-011 SHALL provide port in_last  input  1  marks final beat of frame.
REQ-012 SHALL provide port feat_vec  output  NUM_FEAT*FEAT_W  assembled features to tree; feature k at bits [k*FEAT_W +: FEAT_W].
REQ-013 SHALL provide port tree_class  input  CLASS_W  class from external tree.
REQ-014 SHALL provide port out_valid  output  1  result valid.
REQ-015 SHALL provide port out_ready  input  1  result consumer ready.
REQ-016 SHALL provide port out_class  output  CLASS_W  captured class.
REQ-017 SHALL provide port out_err  output  1  frame length != NUM_FEAT.
REQ-018 SHALL provide port cnt_clear  input  1  synchronous clear of all class counters.
REQ-019 SHALL provide port class_cnt  output  (2**CLASS_W)*CNT_W  counter c at bits [c*CNT_W +: CNT_W].

Function
REQ-020 SHALL implement FSM states LOAD, EVAL, OUTPUT; in_ready=1 only in LOAD; out_valid=1 only in OUTPUT.
REQ-021 SHALL, in LOAD, write accepted beat i (0-based within frame) to feat_vec slice i when i<NUM_FEAT; beats with i>=NUM_FEAT are discarded.
REQ-022 SHALL transition LOAD->EVAL on the cycle after an accepted beat with in_last=1.
REQ-023 SHALL set an error flag for the frame when the beat count at in_last differs from NUM_FEAT (short or long); slices not written in a short frame remain zero.
REQ-024 SHALL hold feat_vec stable throughout EVAL and OUTPUT.
REQ-025 SHALL remain in EVAL exactly EVAL_CYCLES cycles, sample tree_class into out_class on the final EVAL cycle edge, and enter OUTPUT; last beat accepted at edge t gives out_valid high from edge t+EVAL_CYCLES+1.
REQ-026 SHALL hold out_class and out_err stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, on out_valid&out_ready, return to LOAD, clear feat_vec to zero, clear beat index and error flag; the next beat is accepted no earlier than the following cycle.
REQ-028 SHALL increment class_cnt[out_class] by 1 on each output handshake with out_err=0; errored frames are not counted.
REQ-029 SHALL saturate each counter at 2**CNT_W-1 (no wrap).
REQ-030 SHALL give cnt_clear priority over a same-cycle increment (result zero); cnt_clear SHALL not affect FSM or datapath.
REQ-031 SHALL ignore in_data/in_last when in_valid=0 and ignore out_ready outside OUTPUT.
REQ-032 SHALL size the beat index to count up to at least NUM_FEAT without overflow; beyond that it saturates at NUM_FEAT, so error detection holds for arbitrarily long frames.

Reset
REQ-033 SHALL, on rst_n=0 asynchronously: state=LOAD, in_ready=1 after release, out_valid=0, out_class=0, out_err=0, feat_vec=0, beat index=0, all class_cnt=0.
REQ-034 SHALL, on reset mid-frame or mid-OUTPUT, discard the partial frame/pending result with no counter update.

Verification
REQ-035 SHALL cover: defaults, 18 beats 1..18 with in_last on beat 18, tree_class=2 -> out_valid 2 cycles after last beat, out_class=2, out_err=0, class_cnt[2]=1, feat_vec slice 17 =18.
REQ-036 SHALL cover: short frame of 5 beats (value 0xAA) -> slices 0..4 =0xAA, slices 5..17 =0, out_err=1, no counter change.
REQ-037 SHALL cover: 20-beat frame -> beats 19-20 discarded, out_err=1, feat_vec slice 17 = beat 18 value.
REQ-038 SHALL cover: out_ready held low 10 cycles -> out_valid, out_class stable, in_ready=0; release -> one count only.
REQ-039 SHALL cover: CNT_W=2, 5 frames of class 1 -> class_cnt[1]=3; cnt_clear coincident with handshake -> class_cnt[1]=0.
REQ-040 SHALL cover: EVAL_CYCLES=4, tree_class changing 3->1 on the third EVAL cycle -> out_class=1; rst_n pulse in EVAL -> all outputs reset, no count.

Source files
------------

// File: rtl/dtree_stream_harness.sv
// rtl/dtree_stream_harness.sv - streams feature beats into a vector for an external tree and tallies classes
module dtree_stream_harness #(
    parameter int NUM_FEAT    = 18,
    parameter int FEAT_W      = 8,
    parameter int CLASS_W     = 2,
    parameter int EVAL_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [FEAT_W-1:0]               in_data,
    input  logic                            in_last,
    output logic [NUM_FEAT*FEAT_W-1:0]      feat_vec,
    input  logic [CLASS_W-1:0]              tree_class,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CLASS_W-1:0]              out_class,
    output logic                            out_err,
    input  logic                            cnt_clear,
    output logic [(2**CLASS_W)*CNT_W-1:0]   class_cnt
);
    localparam int NUM_CLASS = 2**CLASS_W;
    localparam int IDX_W     = $clog2(NUM_FEAT + 1);
    localparam int EV_W      = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

    typedef enum logic [1:0] {LOAD, EVAL, OUTPUT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] beat_idx;
    logic [EV_W-1:0]  eval_cnt;
    logic             frame_done;
    logic             err_q;
    logic             beat_acc;
    logic             eval_done;
    logic             out_hs;

    assign beat_acc  = in_valid && in_ready;
    assign eval_done = (state_q == EVAL) && (eval_cnt == EV_W'(EVAL_CYCLES - 1));
    assign out_hs    = out_valid && out_ready;
    assign out_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // frame_done holds LOAD one extra cycle so the last beat's slice is settled before EVAL starts
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = !frame_done;
                if (frame_done) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (eval_done) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_vec   <= '0;
            beat_idx   <= '0;
            eval_cnt   <= '0;
            frame_done <= 1'b0;
            err_q      <= 1'b0;
            out_class  <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    eval_cnt <= '0;
                    if (beat_acc) begin
                        for (int k = 0; k < NUM_FEAT; k++) begin
                            if (beat_idx == IDX_W'(k)) begin
                                feat_vec[k*FEAT_W +: FEAT_W] <= in_data;
                            end
                        end
                        // saturating at NUM_FEAT keeps overlong frames flagged however long they run
                        if (beat_idx != IDX_W'(NUM_FEAT)) begin
                            beat_idx <= beat_idx + 1'b1;
                        end
                        if (in_last) begin
                            frame_done <= 1'b1;
                            err_q      <= (beat_idx != IDX_W'(NUM_FEAT - 1));
                        end
                    end
                end
                EVAL: begin
                    frame_done <= 1'b0;
                    eval_cnt   <= eval_cnt + 1'b1;
                    if (eval_done) begin
                        out_class <= tree_class;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        feat_vec <= '0;
                        beat_idx <= '0;
                        err_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                if (cnt_clear) begin
                    class_cnt[c*CNT_W +: CNT_W] <= '0;
                end else if (out_hs && !err_q && (out_class == CLASS_W'(c)) &&
                             (class_cnt[c*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    class_cnt[c*CNT_W +: CNT_W] <= class_cnt[c*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dtree_stream_harness.sv
// tb/tb_dtree_stream_harness.sv - scoreboard bench for dtree_stream_harness (default and small-counter/long-eval builds)
module tb_dtree_stream_harness;
    localparam int NF = 18;
    localparam int FW = 8;
    localparam int P  = 10;

    typedef struct {
        logic [1:0]      cls;
        logic            err;
        logic [NF*FW-1:0] fv;
    } exp_t;

    logic clk = 1'b0;
    always #(P/2) clk = ~clk;

    logic            rst_n, sel, in_valid, in_last, out_ready, cnt_clear;
    logic [FW-1:0]   in_data;
    logic [1:0]      tree_class;
    logic            a_in_ready, b_in_ready, a_out_valid, b_out_valid, a_out_err, b_out_err;
    logic [1:0]      a_out_class, b_out_class;
    logic [NF*FW-1:0] a_feat, b_feat;
    logic [63:0]     a_cnt;
    logic [7:0]      b_cnt;

    logic            m_in_ready, m_out_valid, m_out_err;
    logic [1:0]      m_out_class;
    logic [NF*FW-1:0] m_feat;

    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_out_err   = sel ? b_out_err   : a_out_err;
    assign m_out_class = sel ? b_out_class : a_out_class;
    assign m_feat      = sel ? b_feat      : a_feat;

    dtree_stream_harness u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
        .feat_vec(a_feat), .tree_class(tree_class),
        .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_class(a_out_class), .out_err(a_out_err),
        .cnt_clear(cnt_clear & ~sel), .class_cnt(a_cnt)
    );

    dtree_stream_harness #(.EVAL_CYCLES(4), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
        .feat_vec(b_feat), .tree_class(tree_class),
        .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_class(b_out_class), .out_err(b_out_err),
        .cnt_clear(cnt_clear & sel), .class_cnt(b_cnt)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt[4];
    exp_t sb[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int get_cnt(input int c);
        return sel ? int'(b_cnt[c*2 +: 2]) : int'(a_cnt[c*16 +: 16]);
    endfunction

    task automatic check_counts(input string tag);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_cnt%0d", tag, c), get_cnt(c), exp_cnt[c]);
        end
    endtask

    // mode 0: beat i carries i+1, mode 1: constant 0xAA, mode 2: random
    task automatic send_frame(input int n, input int mode, output logic [NF*FW-1:0] fv, output time t_acc);
        logic [FW-1:0] d;
        int guard;
        fv = '0;
        t_acc = 0;
        for (int i = 0; i < n; i++) begin
            d = (mode == 0) ? FW'(i + 1) : (mode == 1) ? 8'hAA : FW'($urandom_range(0, 255));
            if (i < NF) fv[i*FW +: FW] = d;
            in_valid = 1'b1;
            in_data  = d;
            in_last  = (i == n - 1);
            guard = 0;
            while (!m_in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) check("in_ready_timeout", 0, 1);
            @(posedge clk);
            t_acc = $time;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input int n, input int mode, input int cls, input int hold,
                             input bit clr, input int late_cls);
        logic [NF*FW-1:0] fv;
        time  t_acc, t_seen;
        exp_t e, got_e;
        int   guard;
        int   lat_exp = sel ? 5 : 2;
        int   cmax    = sel ? 3 : 65535;
        tree_class = cls[1:0];
        send_frame(n, mode, fv, t_acc);
        e.cls = (late_cls >= 0) ? late_cls[1:0] : cls[1:0];
        e.err = (n != NF);
        e.fv  = fv;
        sb.push_back(e);
        if (late_cls >= 0) begin
            repeat (3) @(negedge clk);
            tree_class = late_cls[1:0];
        end
        guard = 0;
        while (!m_out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        got_e = sb.pop_front();
        if (guard >= 50) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        t_seen = $time;
        check("latency", (t_seen - t_acc - P/2) / P, lat_exp);
        check("out_class", m_out_class, got_e.cls);
        check("out_err", m_out_err, got_e.err);
        check("feat_vec", m_feat, got_e.fv);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", m_out_valid, 1);
            check("hold_class", m_out_class, got_e.cls);
            check("hold_in_ready", m_in_ready, 0);
        end
        out_ready = 1'b1;
        cnt_clear = clr;
        @(posedge clk);
        if (clr) begin
            for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        end else if (!got_e.err && exp_cnt[got_e.cls] < cmax) begin
            exp_cnt[got_e.cls]++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        cnt_clear = 1'b0;
        check("post_hs_valid", m_out_valid, 0);
        check("post_hs_feat", m_feat, 0);
        check("post_hs_in_ready", m_in_ready, 1);
        check_counts("post_hs");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NF*FW-1:0] fv;
        time t_acc;
        int  seen;
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b0; cnt_clear = 1'b0; tree_class = '0;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", m_out_valid, 0);
        check("rst_out_class", m_out_class, 0);
        check("rst_out_err", m_out_err, 0);
        check("rst_feat", m_feat, 0);
        check("rst_cnt", a_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", m_in_ready, 1);

        run_frame(18, 0, 2, 0, 1'b0, -1);
        check("first_cnt2", get_cnt(2), 1);
        run_frame(5, 1, 1, 0, 1'b0, -1);
        run_frame(20, 0, 3, 0, 1'b0, -1);
        run_frame(18, 2, 0, 10, 1'b0, -1);
        check("held_cnt0", get_cnt(0), 1);

        sel = 1'b1;
        do_reset();
        for (int f = 0; f < 5; f++) run_frame(18, 2, 1, 0, 1'b0, -1);
        check("sat_cnt1", get_cnt(1), 3);
        run_frame(18, 0, 1, 0, 1'b1, -1);
        check("clear_cnt1", get_cnt(1), 0);
        run_frame(18, 0, 3, 0, 1'b0, 1);
        check("late_cnt1", get_cnt(1), 1);

        tree_class = 2'd2;
        send_frame(18, 0, fv, t_acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("eval_rst_valid", m_out_valid, 0);
        check("eval_rst_class", m_out_class, 0);
        check("eval_rst_feat", m_feat, 0);
        check("eval_rst_cnt", b_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_out_valid) seen++;
        end
        check("eval_rst_no_output", seen, 0);
        check("eval_rst_in_ready", m_in_ready, 1);
        check_counts("eval_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
